pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline-control stage that owns the opcode tracking registers (ID, EX, MEM, WB) for the A/B accumulator pipeline. It feeds `instruction_ID`, `instruction_EX` and `instruction_MEM` to the forwarding unit directly downstream. It detects load-use hazards that forwarding cannot cover and inserts bubbles, flushes on taken branches, and freezes on memory wait.

## Interface
Parameters:
- `OPW`, 6, opcode width (matches the shared opcode definitions).
- `CNTW`, 16, width of the performance counters (only used with `PIPE_CTRL_PERF_EN`).

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_IF`  in  OPW  opcode fetched this cycle.
- `valid_IF`  in  1  `instr_IF` is valid; when low, a NOP enters ID.
- `branch_taken`  in  1  branch resolved taken in EX; flush the younger stages.
- `freeze`  in  1  memory wait; hold every stage.
- `instruction_ID`, `instruction_EX`, `instruction_MEM`, `instruction_WB`  out  OPW each  registered stage opcodes.
- `stall`  out  1  combinational; hold PC and the IF/ID latch this cycle.
- `stall_count`, `flush_count`  out  CNTW each  present only with `PIPE_CTRL_PERF_EN`.

## Operation
- Decode classes:
  - readsA = {STA, ADDA, ADDB, ADDCA, SUBA, SUBB, SUBCA, ANDA, ANDB, ANDCA, ORA, ORB, ORCA, ASLA, ASRA}.
  - readsB = {STB, ADDA, ADDB, ADDCB, SUBA, SUBB, SUBCB, ANDA, ANDB, ANDCB, ORA, ORB, ORCB}.
  - memLoadA = {LDA}; memLoadB = {LDB}. LDCA and LDCB are not memory loads, because EX forwarding covers them.
- Hazard: `hz = (readsA(ID) & memLoadA(EX)) | (readsB(ID) & memLoadB(EX))`.
- `stall = hz & ~branch_taken & ~freeze`.
- Per-edge update, in priority order:
  1. freeze: all four registers hold; counters hold.
  2. branch_taken: ID <= NOP, EX <= NOP, MEM <= EX, WB <= MEM; `flush_count` +1.
  3. hz: ID holds, EX <= NOP (bubble), MEM <= EX, WB <= MEM; `stall_count` +1.
  4. Normal: ID <= valid_IF ? instr_IF : NOP, EX <= ID, MEM <= EX, WB <= MEM.
- An opcode outside every class behaves as a non-reader and non-loader (no stall); it still propagates down the pipeline.
- Counters saturate at 2^CNTW−1 and do not wrap.

## Timing
- Reset (async assert, sync release on the next edge):
  - all `instruction_*` = NOP (6'h00).
  - `stall` = 0.
  - counters = 0.
- Reset mid-stall or mid-flush discards the in-flight state fully.
- Opcode latency IF→ID→EX→MEM→WB is one cycle per stage.
- A load-use pair costs exactly one bubble. After the bubble the load sits in MEM and the consumer is in ID, so the forwarding unit raises its MEM select on the next edge.
- `stall` is valid in the same cycle as the hazard and is never high for two consecutive cycles on the same instruction pair.
- A simultaneous hazard and `branch_taken`: the flush wins, `stall` = 0, and no stall is counted.
- Freeze while a hazard exists: `stall` = 0 and the hazard is re-evaluated after the freeze drops.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_count` and `flush_count` ports and their saturating counters exist.
- Undefined: ports and logic are absent and the rest of the behaviour is identical.

## Structure
- All opcode constants, including NOP = 6'h00, belong in the shared definitions file. No local opcode literals are allowed.
- Sub-module `opcode_class_decode` (combinational): opcode in; readsA, readsB, memLoadA, memLoadB out. Instantiate it once for ID and once for EX.

## Test plan
- Reset check: assert `rst_n`=0 mid-stream → all stages = NOP and `stall`=0 asynchronously. Release and feed LDCA, ADDA → no stall, and ADDA reaches EX two edges after entry.
- Load-use on A: feed LDA then ADDA → `stall`=1 for one cycle, EX=NOP next edge, then ADDA in EX with LDA in WB. `stall_count`=1.
- Load-use on B without a match: feed LDB then ASLA → no stall, because ASLA does not read B.
- Flush beats stall: LDA in EX, STA in ID, `branch_taken`=1 → `stall`=0, ID=EX=NOP, MEM=LDA. `flush_count`=1, `stall_count` unchanged.
- Freeze: LDA in EX, SUBA in ID, `freeze`=1 for 3 cycles → all stages held and `stall`=0. After release, `stall`=1 for one cycle.
- Saturation with PERF_EN: set CNTW=2 and force 5 stalls → `stall_count`=3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode definitions and class flags for the A/B accumulator pipeline.
package pipe_ctrl_pkg;

  localparam int OP_W = 6;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_NOP   = 6'h00;
  localparam opcode_t OP_LDA   = 6'h01;
  localparam opcode_t OP_LDB   = 6'h02;
  localparam opcode_t OP_LDCA  = 6'h03;
  localparam opcode_t OP_LDCB  = 6'h04;
  localparam opcode_t OP_STA   = 6'h05;
  localparam opcode_t OP_STB   = 6'h06;
  localparam opcode_t OP_ADDA  = 6'h07;
  localparam opcode_t OP_ADDB  = 6'h08;
  localparam opcode_t OP_ADDCA = 6'h09;
  localparam opcode_t OP_ADDCB = 6'h0A;
  localparam opcode_t OP_SUBA  = 6'h0B;
  localparam opcode_t OP_SUBB  = 6'h0C;
  localparam opcode_t OP_SUBCA = 6'h0D;
  localparam opcode_t OP_SUBCB = 6'h0E;
  localparam opcode_t OP_ANDA  = 6'h0F;
  localparam opcode_t OP_ANDB  = 6'h10;
  localparam opcode_t OP_ANDCA = 6'h11;
  localparam opcode_t OP_ANDCB = 6'h12;
  localparam opcode_t OP_ORA   = 6'h13;
  localparam opcode_t OP_ORB   = 6'h14;
  localparam opcode_t OP_ORCA  = 6'h15;
  localparam opcode_t OP_ORCB  = 6'h16;
  localparam opcode_t OP_ASLA  = 6'h17;
  localparam opcode_t OP_ASRA  = 6'h18;

  typedef struct packed {
    logic reads_a;
    logic reads_b;
    logic load_a;
    logic load_b;
  } op_class_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode classifier: which accumulators an opcode reads and
// whether it is a memory load into A or B.
module opcode_class_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW = OP_W
) (
  input  logic [OPW-1:0] opcode,
  output logic           reads_a,
  output logic           reads_b,
  output logic           mem_load_a,
  output logic           mem_load_b
);

  op_class_t cls;

  always_comb begin
    cls = '0;
    case (opcode)
      OPW'(OP_LDA):  cls.load_a = 1'b1;
      OPW'(OP_LDB):  cls.load_b = 1'b1;
      // Register-sourced loads resolve in EX and are covered by forwarding.
      OPW'(OP_LDCA),
      OPW'(OP_LDCB): cls = '0;
      OPW'(OP_STA),
      OPW'(OP_ADDCA),
      OPW'(OP_SUBCA),
      OPW'(OP_ANDCA),
      OPW'(OP_ORCA),
      OPW'(OP_ASLA),
      OPW'(OP_ASRA): cls.reads_a = 1'b1;
      OPW'(OP_STB),
      OPW'(OP_ADDCB),
      OPW'(OP_SUBCB),
      OPW'(OP_ANDCB),
      OPW'(OP_ORCB): cls.reads_b = 1'b1;
      OPW'(OP_ADDA),
      OPW'(OP_ADDB),
      OPW'(OP_SUBA),
      OPW'(OP_SUBB),
      OPW'(OP_ANDA),
      OPW'(OP_ANDB),
      OPW'(OP_ORA),
      OPW'(OP_ORB): begin
        cls.reads_a = 1'b1;
        cls.reads_b = 1'b1;
      end
      default: cls = '0;
    endcase
  end

  assign reads_a    = cls.reads_a;
  assign reads_b    = cls.reads_b;
  assign mem_load_a = cls.load_a;
  assign mem_load_b = cls.load_b;

endmodule

// File: rtl/pipe_ctrl.sv
// Opcode tracking registers ID/EX/MEM/WB with load-use bubbles, branch flush
// and memory-wait freeze. PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  instr_IF,
  input  logic            valid_IF,
  input  logic            branch_taken,
  input  logic            freeze,
  output logic [OPW-1:0]  instruction_ID,
  output logic [OPW-1:0]  instruction_EX,
  output logic [OPW-1:0]  instruction_MEM,
  output logic [OPW-1:0]  instruction_WB,
  output logic            stall
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNTW-1:0] stall_count,
  output logic [CNTW-1:0] flush_count
`endif
);

  localparam logic [OPW-1:0] NOP = OPW'(OP_NOP);

  logic id_reads_a, id_reads_b, id_load_a, id_load_b;
  logic ex_reads_a, ex_reads_b, ex_load_a, ex_load_b;
  logic hz;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  opcode_class_decode #(.OPW(OPW)) u_dec_id (
    .opcode     (instruction_ID),
    .reads_a    (id_reads_a),
    .reads_b    (id_reads_b),
    .mem_load_a (id_load_a),
    .mem_load_b (id_load_b)
  );

  opcode_class_decode #(.OPW(OPW)) u_dec_ex (
    .opcode     (instruction_EX),
    .reads_a    (ex_reads_a),
    .reads_b    (ex_reads_b),
    .mem_load_a (ex_load_a),
    .mem_load_b (ex_load_b)
  );

  // Only EX-stage memory loads matter; ID's load flags and EX's read flags are
  // produced by the shared decoder but carry no hazard information here.
  logic unused_flags;
  assign unused_flags = id_load_a | id_load_b | ex_reads_a | ex_reads_b;

  assign hz    = (id_reads_a & ex_load_a) | (id_reads_b & ex_load_b);
  assign stall = hz & ~branch_taken & ~freeze;

  // Stage registers: freeze > flush > bubble > advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_ID  <= NOP;
      instruction_EX  <= NOP;
      instruction_MEM <= NOP;
      instruction_WB  <= NOP;
    end else if (!freeze) begin
      instruction_MEM <= instruction_EX;
      instruction_WB  <= instruction_MEM;
      if (branch_taken) begin
        instruction_ID <= NOP;
        instruction_EX <= NOP;
      end else if (hz) begin
        instruction_EX <= NOP;
      end else begin
        instruction_ID <= valid_IF ? instr_IF : NOP;
        instruction_EX <= instruction_ID;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!freeze) begin
      if (branch_taken) begin
        flush_count <= sat_inc(flush_count);
      end else if (hz) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a list-based reference model of the stage opcodes and counters.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int OPW  = 6;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [OPW-1:0]  instr_IF = '0;
  logic            valid_IF = 1'b0;
  logic            branch_taken = 1'b0;
  logic            freeze = 1'b0;
  logic [OPW-1:0]  instruction_ID, instruction_EX, instruction_MEM, instruction_WB;
  logic            stall;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNTW-1:0] stall_count, flush_count;
`endif

  pipe_ctrl #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_IF        (instr_IF),
    .valid_IF        (valid_IF),
    .branch_taken    (branch_taken),
    .freeze          (freeze),
    .instruction_ID  (instruction_ID),
    .instruction_EX  (instruction_EX),
    .instruction_MEM (instruction_MEM),
    .instruction_WB  (instruction_WB),
    .stall           (stall)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // Reference model: stage list [0]=ID [1]=EX [2]=MEM [3]=WB
  logic [5:0] m_st[4];
  int m_sc, m_fc;

  logic [5:0] reads_a_set[$] = '{OP_STA, OP_ADDA, OP_ADDB, OP_ADDCA, OP_SUBA, OP_SUBB,
                                 OP_SUBCA, OP_ANDA, OP_ANDB, OP_ANDCA, OP_ORA, OP_ORB,
                                 OP_ORCA, OP_ASLA, OP_ASRA};
  logic [5:0] reads_b_set[$] = '{OP_STB, OP_ADDA, OP_ADDB, OP_ADDCB, OP_SUBA, OP_SUBB,
                                 OP_SUBCB, OP_ANDA, OP_ANDB, OP_ANDCB, OP_ORA, OP_ORB,
                                 OP_ORCB};
  logic [5:0] rand_ops[$] = '{OP_NOP, OP_LDA, OP_LDB, OP_LDCA, OP_LDCB, OP_STA, OP_STB,
                              OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB, OP_SUBA, OP_SUBB,
                              OP_SUBCA, OP_SUBCB, OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB,
                              OP_ORA, OP_ORB, OP_ORCA, OP_ORCB, OP_ASLA, OP_ASRA,
                              6'h3F, 6'h2A, OP_LDA, OP_LDB};

  function automatic bit in_list(input logic [5:0] op, input logic [5:0] q[$]);
    foreach (q[i]) if (q[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_hz();
    return (in_list(m_st[0], reads_a_set) && m_st[1] == OP_LDA) ||
           (in_list(m_st[0], reads_b_set) && m_st[1] == OP_LDB);
  endfunction

  function automatic bit model_stall(input logic br, input logic fz);
    return model_hz() && !br && !fz;
  endfunction

  task automatic model_reset();
    foreach (m_st[i]) m_st[i] = OP_NOP;
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic model_step(input logic [5:0] op, input logic v, input logic br, input logic fz);
    logic [5:0] nx[4];
    if (fz) return;
    if (br) begin
      nx = '{OP_NOP, OP_NOP, m_st[1], m_st[2]};
      if (m_fc < CMAX) m_fc++;
    end else if (model_hz()) begin
      nx = '{m_st[0], OP_NOP, m_st[1], m_st[2]};
      if (m_sc < CMAX) m_sc++;
    end else begin
      nx = '{(v ? op : OP_NOP), m_st[0], m_st[1], m_st[2]};
    end
    m_st = nx;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("ID",  32'(instruction_ID),  32'(m_st[0]));
    chk("EX",  32'(instruction_EX),  32'(m_st[1]));
    chk("MEM", 32'(instruction_MEM), 32'(m_st[2]));
    chk("WB",  32'(instruction_WB),  32'(m_st[3]));
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_count", 32'(stall_count), 32'(m_sc));
    chk("flush_count", 32'(flush_count), 32'(m_fc));
`endif
  endtask

  task automatic cycle(input logic [5:0] op, input logic v, input logic br, input logic fz);
    instr_IF = op;
    valid_IF = v;
    branch_taken = br;
    freeze = fz;
    #1;
    chk("stall", 32'(stall), 32'(model_stall(br, fz)));
    @(posedge clk);
    model_step(op, v, br, fz);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    instr_IF = '0;
    valid_IF = 1'b0;
    branch_taken = 1'b0;
    freeze = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ID",  32'(instruction_ID),  32'(OP_NOP));
    chk("rst_EX",  32'(instruction_EX),  32'(OP_NOP));
    chk("rst_MEM", 32'(instruction_MEM), 32'(OP_NOP));
    chk("rst_WB",  32'(instruction_WB),  32'(OP_NOP));
    chk("rst_stall", 32'(stall), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_flush_count", 32'(flush_count), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(OP_NOP, 1'b0, 1'b0, 1'b0);
    #1;
    check_state();
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Reset mid-stall discards the pending bubble and the stall.
    cycle(OP_LDA, 1'b1, 1'b0, 1'b0);
    cycle(OP_ADDA, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_stall", 32'(stall), 32'd1);
    do_reset();

    // LDCA then ADDA: forwarding covers it, no stall.
    cycle(OP_LDCA, 1'b1, 1'b0, 1'b0);
    cycle(OP_ADDA, 1'b1, 1'b0, 1'b0);
    chk("ldca_no_stall", 32'(stall), 32'd0);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    chk("ldca_adda_in_ex", 32'(instruction_EX), 32'(OP_ADDA));

    // Load-use on A costs exactly one bubble.
    do_reset();
    cycle(OP_LDA, 1'b1, 1'b0, 1'b0);
    cycle(OP_ADDA, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", 32'(stall), 32'd1);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    chk("lu_bubble_ex", 32'(instruction_EX), 32'(OP_NOP));
    chk("lu_hold_id", 32'(instruction_ID), 32'(OP_ADDA));
    chk("lu_stall_drop", 32'(stall), 32'd0);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    chk("lu_adda_ex", 32'(instruction_EX), 32'(OP_ADDA));
    chk("lu_lda_wb", 32'(instruction_WB), 32'(OP_LDA));
`ifdef PIPE_CTRL_PERF_EN
    chk("lu_stall_count", 32'(stall_count), 32'd1);
`endif

    // LDB then ASLA: ASLA does not read B.
    do_reset();
    cycle(OP_LDB, 1'b1, 1'b0, 1'b0);
    cycle(OP_ASLA, 1'b1, 1'b0, 1'b0);
    chk("ldb_asla_stall", 32'(stall), 32'd0);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    chk("ldb_asla_ex", 32'(instruction_EX), 32'(OP_ASLA));

    // Unclassified opcode propagates without stalling.
    do_reset();
    cycle(OP_LDA, 1'b1, 1'b0, 1'b0);
    cycle(6'h3F, 1'b1, 1'b0, 1'b0);
    chk("unknown_stall", 32'(stall), 32'd0);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    chk("unknown_ex", 32'(instruction_EX), 32'h3F);

    // Flush beats stall.
    do_reset();
    cycle(OP_LDA, 1'b1, 1'b0, 1'b0);
    cycle(OP_STA, 1'b1, 1'b0, 1'b0);
    chk("flush_pre_hz", 32'(stall), 32'd1);
    cycle(OP_ADDB, 1'b1, 1'b1, 1'b0);
    chk("flush_id", 32'(instruction_ID), 32'(OP_NOP));
    chk("flush_ex", 32'(instruction_EX), 32'(OP_NOP));
    chk("flush_mem", 32'(instruction_MEM), 32'(OP_LDA));
`ifdef PIPE_CTRL_PERF_EN
    chk("flush_flush_count", 32'(flush_count), 32'd1);
    chk("flush_stall_count", 32'(stall_count), 32'd0);
`endif

    // Freeze over a live hazard, then the hazard resurfaces.
    do_reset();
    cycle(OP_LDA, 1'b1, 1'b0, 1'b0);
    cycle(OP_SUBA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(OP_ADDB, 1'b1, 1'b0, 1'b1);
      chk("frz_id", 32'(instruction_ID), 32'(OP_SUBA));
      chk("frz_ex", 32'(instruction_EX), 32'(OP_LDA));
    end
    freeze = 1'b1;
    #1;
    chk("frz_stall", 32'(stall), 32'd0);
    freeze = 1'b0;
    #1;
    chk("frz_release_stall", 32'(stall), 32'd1);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    chk("frz_suba_ex", 32'(instruction_EX), 32'(OP_SUBA));

    // Five load-use pairs saturate a 2-bit stall counter at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(OP_LDB, 1'b1, 1'b0, 1'b0);
      cycle(OP_ORB, 1'b1, 1'b0, 1'b0);
      cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
      cycle(OP_NOP, 1'b0, 1'b0, 1'b0);
    end
`ifdef PIPE_CTRL_PERF_EN
    chk("sat_stall_count", 32'(stall_count), 32'(CMAX));
`endif

    // Random traffic with occasional flush, freeze and reset.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle(rand_ops[$urandom_range(0, rand_ops.size() - 1)],
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
